// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the core's load/store interface.
// One request at a time over valid/ready, WAIT_CYCLES wait states, then a
// big-endian byte/half/word access to an internal byte array.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned/reserved-size
// requests complete with rsp_err instead of being force-aligned).
module dmem_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW        = $clog2(DEPTH_BYTES);
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_WAIT   = 2'd1;
  localparam logic [1:0]  ST_RESP   = 2'd2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  // Sign- or zero-extend a byte to 32 bits.
  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    ext8 = {{24{sgn & b[7]}}, b};
  endfunction

  // Sign- or zero-extend a halfword to 32 bits.
  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    ext16 = {{16{sgn & h[15]}}, h};
  endfunction

  logic [7:0]    mem_q [DEPTH_BYTES];
  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          ready_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;

  logic          access_s;
  logic          fault_s;
  logic [1:0]    size_eff_s;
  logic [AW-1:0] b0_s, b1_s, b2_s, b3_s;
  logic [31:0]   rdata_s;
  logic          unused_addr_s;

  // Address bits above the array size wrap silently.
  assign unused_addr_s = ^req_addr[31:AW];

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // The access happens on the edge that leaves WAIT with the counter drained.
  assign access_s = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  // Decode the latched request: fault detection, effective size and base.
  always_comb begin
    size_eff_s = (size_q == 2'b11) ? 2'b10 : size_q;
`ifdef DMEM_MISALIGN_TRAP_EN
    case (size_q)
      2'b00:   fault_s = 1'b0;
      2'b01:   fault_s = addr_q[0];
      2'b10:   fault_s = |addr_q[1:0];
      default: fault_s = 1'b1;
    endcase
    b0_s = addr_q;
`else
    fault_s = 1'b0;
    case (size_eff_s)
      2'b01:   b0_s = addr_q & ~AW'(1);
      2'b10:   b0_s = addr_q & ~AW'(3);
      default: b0_s = addr_q;
    endcase
`endif
    b1_s = b0_s + AW'(1);
    b2_s = b0_s + AW'(2);
    b3_s = b0_s + AW'(3);
  end

  // Assemble big-endian load data; stores and faults return zero.
  always_comb begin
    rdata_s = 32'd0;
    if (write_q || fault_s) begin
      rdata_s = 32'd0;
    end else begin
      case (size_eff_s)
        2'b00:   rdata_s = ext8(mem_q[b0_s], signed_q);
        2'b01:   rdata_s = ext16({mem_q[b0_s], mem_q[b1_s]}, signed_q);
        2'b10:   rdata_s = {mem_q[b0_s], mem_q[b1_s], mem_q[b2_s], mem_q[b3_s]};
        default: rdata_s = 32'd0;
      endcase
    end
  end

  // Next-state logic for IDLE -> WAIT -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control state, request latch and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= (state_d == ST_IDLE);
      rsp_valid_q <= access_s;
      if ((state_q == ST_IDLE) && req_valid) begin
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr[AW-1:0];
        wdata_q  <= req_wdata;
      end
      if (access_s) begin
        rsp_rdata_q <= rdata_s;
        rsp_err_q   <= fault_s;
      end
    end
  end

  // Array write; contents are deliberately not reset. A reset before the
  // access edge forces IDLE, so a pending store is never committed.
  always_ff @(posedge clk) begin
    if (access_s && write_q && !fault_s) begin
      case (size_eff_s)
        2'b00: mem_q[b0_s] <= wdata_q[7:0];
        2'b01: begin
          mem_q[b0_s] <= wdata_q[15:8];
          mem_q[b1_s] <= wdata_q[7:0];
        end
        2'b10: begin
          mem_q[b0_s] <= wdata_q[31:24];
          mem_q[b1_s] <= wdata_q[23:16];
          mem_q[b2_s] <= wdata_q[15:8];
          mem_q[b3_s] <= wdata_q[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed test-plan steps plus
// randomized accesses checked against a byte-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WAITC = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] model_mem [DEPTH];

  dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: apply the access rules directly to a byte array.
  task automatic model_access(input logic w, input logic [1:0] sz, input logic sg,
                              input logic [31:0] ad, input logic [31:0] wd,
                              output logic [31:0] er, output logic ee);
    int a;
    int nb;
    logic [31:0] v;
    a  = int'(ad % DEPTH);
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    er = 32'd0;
    ee = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (sz == 2'b11 || (a % nb) != 0) begin
      ee = 1'b1;
      return;
    end
`endif
    a = a - (a % nb);
    if (w) begin
      for (int i = 0; i < nb; i++) begin
        v = wd >> (8 * (nb - 1 - i));
        model_mem[a + i] = v[7:0];
      end
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = (v << 8) + {24'd0, model_mem[a + i]};
      if (sg && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8 * nb));
      er = v;
    end
  endtask

  task automatic do_access(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd,
                           output logic [31:0] got);
    logic [31:0] er;
    logic ee;
    int n;
    model_access(w, sz, sg, ad, wd, er, ee);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) chk("ready_wait", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("busy_c1", {31'd0, req_ready}, 32'd0);
    // Garbage while busy must be ignored.
    req_write = ~w; req_size = 2'($urandom); req_signed = ~sg;
    req_addr = $urandom; req_wdata = $urandom;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    req_valid = 1'b0;
    chk("latency", 32'(n), 32'(WAITC + 2));
    chk("rdata", rsp_rdata, er);
    chk("err", {31'd0, rsp_err}, {31'd0, ee});
    got = rsp_rdata;
    @(posedge clk); #1;
    chk("valid_pulse", {31'd0, rsp_valid}, 32'd0);
    chk("ready_back", {31'd0, req_ready}, 32'd1);
    chk("rdata_hold", rsp_rdata, er);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] e;
    logic ee;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, got);
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
    chk("plan_word", got, 32'hDEADBEEF);
    do_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, got);
    chk("plan_byte_s", got, 32'hFFFFFFEF);
    do_access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, got);
    chk("plan_byte_u", got, 32'h000000EF);
    do_access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, got);
    chk("plan_half_s", got, 32'hFFFFDEAD);
    do_access(1'b1, 2'b00, 1'b0, 32'h11, 32'h55, got);
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
    chk("plan_bstore", got, 32'hDE55BEEF);
    do_access(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234, got);
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
    chk("plan_hstore", got, 32'hDE551234);
    do_access(1'b1, 2'b10, 1'b0, DEPTH + 32'h20, 32'hA5A5A5A5, got);
    do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, got);
    chk("plan_wrap", got, 32'hA5A5A5A5);

    do_access(1'b1, 2'b01, 1'b0, 32'h11, 32'hCAFE, got);
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("plan_misalign", got, 32'hDE551234);
`else
    chk("plan_misalign", got, 32'hCAFE1234);
`endif

    // Reset abort of an accepted store.
    do_access(1'b1, 2'b10, 1'b0, 32'h40, 32'h11111111, got);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h22222222;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_accepted", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rdata", rsp_rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_novalid", {31'd0, rsp_valid}, 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_novalid2", {31'd0, rsp_valid}, 32'd0);
    do_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, got);
    chk("abort_kept", got, 32'h11111111);

    // Fill the random region, then random traffic with random upper bits.
    for (int i = 0; i < 64; i++)
      do_access(1'b1, 2'b10, 1'b0, 32'h100 + 32'(4 * i), $urandom, got);
    for (int i = 0; i < 150; i++) begin
      e = ($urandom & ~32'(DEPTH - 1)) | (32'h100 + 32'($urandom_range(0, 255)));
      ee = 1'($urandom);
      do_access(ee, 2'($urandom), 1'($urandom), e, $urandom, got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
